aes128_iter_core: RTL

Iterative AES-128 encryption core built around the existing sub_byte, shift_rows, mix_columns and key_expansion blocks. It generalises the single combinational round into a clocked engine that runs UNROLL rounds per clock. The key schedule is computed on the fly, and the final round correctly omits MixColumns. The block sits between a block-level data source and sink, with valid/ready handshakes on both sides.

---
 rtl/aes128_iter_core.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/aes128_iter_core.sv
// aes128_iter_core
//   Iterative AES-128 encryption engine. A block is accepted on the input
//   handshake, then UNROLL rounds are evaluated per clock with the key
//   schedule expanded on the fly. The final round (round 10) skips MixColumns.
//   The ciphertext is held stable until the sink accepts it.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   source offers pt/key
//   in_ready   core can accept a block (decoded from state)
//   key, pt    128-bit key / plaintext, sampled on the input handshake
//   out_valid  ct is valid (registered)
//   out_ready  sink accepts ct
//   ct         ciphertext (registered)
//   busy       high in RUN and DONE (decoded from state)
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// RUN   | evaluating UNROLL rounds per clock
// DONE  | ct/out_valid held until out_ready

module aes128_iter_core #(
   parameter int UNROLL = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] key,
   input  logic [127:0] pt,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ct,
   output logic         busy
);

   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
      $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Byte 0 of the state is bits [127:120]; column c holds bytes 4c..4c+3.
   function automatic logic [127:0] sub_byte(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int b = 0; b < 16; b++) begin
         r[127-8*b -: 8] = SBOX[s[127-8*b -: 8]];
      end
      return r;
   endfunction

   // Row w of output column c comes from column (c+w) mod 4.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int w = 0; w < 4; w++) begin
            r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      case (rnd)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] key_expansion(input logic [3:0] rnd, input logic [127:0] k);
      logic [31:0] w3, t, n0, n1, n2, n3;
      w3 = k[31:0];
      t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]}
           ^ {rcon(rnd), 24'h0};
      n0 = k[127:96] ^ t;
      n1 = k[95:64]  ^ n0;
      n2 = k[63:32]  ^ n1;
      n3 = w3        ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   state_t       state;
   logic [127:0] st, rk;
   logic [3:0]   rc;

   logic [127:0] s_nx, k_nx;
   logic [3:0]   rnd;
   logic         last_hit;

   // UNROLL chained rounds starting at round rc; round 10 omits MixColumns.
   always_comb begin
      s_nx     = st;
      k_nx     = rk;
      rnd      = '0;
      last_hit = 1'b0;
      for (int i = 0; i < UNROLL; i++) begin
         rnd  = rc + 4'(i);
         k_nx = key_expansion(rnd, k_nx);
         if (rnd == 4'd10) begin
            s_nx     = shift_rows(sub_byte(s_nx)) ^ k_nx;
            last_hit = 1'b1;
         end else begin
            s_nx = mix_columns(shift_rows(sub_byte(s_nx))) ^ k_nx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         st        <= '0;
         rk        <= '0;
         rc        <= '0;
         ct        <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  st    <= pt ^ key;
                  rk    <= key;
                  rc    <= 4'd1;
                  state <= RUN;
               end
            end
            RUN: begin
               st <= s_nx;
               rk <= k_nx;
               if (last_hit) begin
                  // rc parks at 0 so it never holds the post-final value 11.
                  ct        <= s_nx;
                  out_valid <= 1'b1;
                  rc        <= '0;
                  state     <= DONE;
               end else begin
                  rc <= rc + 4'(UNROLL);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

endmodule
